note_recorder: RTL and testbench



---
 rtl/note_recorder_pkg.sv | 17 +
 rtl/note_buffer.sv | 26 ++
 rtl/note_recorder.sv | 130 +++++++++++++
 tb/tb_note_recorder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/note_recorder_pkg.sv
// Shared field widths and FSM encoding for the free-play note recorder.
package note_recorder_pkg;

  localparam int OCTAVE_BITS = 3;
  localparam int NOTE_BITS   = 4;
  localparam int LENGTH_BITS = 3;
  localparam int ENTRY_BITS  = OCTAVE_BITS + NOTE_BITS + LENGTH_BITS;

  typedef enum logic [2:0] {
    REC_IDLE  = 3'd0,
    REC_REC   = 3'd1,
    REC_ISSUE = 3'd2,
    REC_ACK   = 3'd3,
    REC_WAIT  = 3'd4
  } rec_state_e;

endpackage

// File: rtl/note_buffer.sv
// Recorded-note storage: synchronous write, combinational read, no reset.
module note_buffer
  import note_recorder_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [ENTRY_BITS-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [ENTRY_BITS-1:0] rdata
);

  logic [ENTRY_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/note_recorder.sv
// Record/playback engine: captures struck notes, then replays them one at a
// time to the sound generator over a start/busy handshake.
module note_recorder
  import note_recorder_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   rec,
  input  logic                   play,
  input  logic                   stop,
  input  logic                   hit,
  input  logic [OCTAVE_BITS-1:0] octave_in,
  input  logic [NOTE_BITS-1:0]   note_in,
  input  logic [LENGTH_BITS-1:0] length_in,
  input  logic                   sd_busy,
  output logic                   sd_start,
  output logic [OCTAVE_BITS-1:0] octave_out,
  output logic [NOTE_BITS-1:0]   note_out,
  output logic [LENGTH_BITS-1:0] length_out,
  output logic [ADDR_W:0]        count,
  output logic                   full,
  output logic                   busy,
  output logic                   done
);

  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  rec_state_e             state_q, state_d;
  logic [ADDR_W:0]        count_q, count_d;
  logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic                   done_q, done_d;
  logic [ENTRY_BITS-1:0]  entry_q;
  logic                   we;
  logic                   load;
  logic [ENTRY_BITS-1:0]  rdata;

  note_buffer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_buffer (
    .clk   (clk),
    .we    (we),
    .waddr (count_q[ADDR_W-1:0]),
    .wdata ({octave_in, note_in, length_in}),
    .raddr (rd_ptr_d),
    .rdata (rdata)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    done_d   = 1'b0;
    we       = 1'b0;
    load     = 1'b0;
    if (!en || stop) begin
      state_d = REC_IDLE;
    end else begin
      case (state_q)
        REC_IDLE: begin
          if (rec) begin
            state_d = REC_REC;
            count_d = '0;
          end else if (play && count_q != '0) begin
            state_d  = REC_ISSUE;
            rd_ptr_d = '0;
            load     = 1'b1;
          end
        end
        REC_REC: begin
          // play outranks hit, so a coincident hit is dropped as well
          if (rec) begin
            state_d = REC_IDLE;
          end else if (!play && hit && !full) begin
            we      = 1'b1;
            count_d = count_q + CNT_ONE;
          end
        end
        REC_ISSUE: state_d = REC_ACK;
        REC_ACK: begin
          if (sd_busy) state_d = REC_WAIT;
        end
        REC_WAIT: begin
          if (!sd_busy) begin
            if ({1'b0, rd_ptr_q} == count_q - CNT_ONE) begin
              state_d = REC_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d  = REC_ISSUE;
              rd_ptr_d = rd_ptr_q + PTR_ONE;
              load     = 1'b1;
            end
          end
        end
        default: state_d = REC_IDLE;
      endcase
    end
  end

  // Output entry is captured on entry to ISSUE so it is valid with sd_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= REC_IDLE;
      count_q  <= '0;
      rd_ptr_q <= '0;
      done_q   <= 1'b0;
      entry_q  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      done_q   <= done_d;
      if (load) entry_q <= rdata;
    end
  end

  assign sd_start = (state_q == REC_ISSUE);
  assign {octave_out, note_out, length_out} = entry_q;
  assign count = count_q;
  assign full  = (count_q == DEPTH_C);
  assign busy  = (state_q != REC_IDLE);
  assign done  = done_q;

endmodule

// File: tb/tb_note_recorder.sv
// Scoreboard bench for note_recorder: recorded notes are modelled, pushed as
// expected playback entries on play, and popped on each sd_start.
module tb_note_recorder;
  import note_recorder_pkg::*;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0, en = 1'b0, rec = 1'b0, play = 1'b0, stop = 1'b0, hit = 1'b0;
  logic sd_busy = 1'b0;
  logic [2:0] octave_in = '0;
  logic [3:0] note_in = '0;
  logic [2:0] length_in = '0;
  logic sd_start, full, busy, done;
  logic [2:0] octave_out, length_out;
  logic [3:0] note_out;
  logic [ADDR_W:0] count;

  note_recorder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rec(rec), .play(play), .stop(stop),
    .hit(hit), .octave_in(octave_in), .note_in(note_in), .length_in(length_in),
    .sd_busy(sd_busy), .sd_start(sd_start), .octave_out(octave_out),
    .note_out(note_out), .length_out(length_out), .count(count), .full(full),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  int start_cnt = 0, done_cnt = 0, last_fall_cyc = 0;
  int resp_idx = 0, resp_base = 0, stall_at = -1;
  int model_count = 0;
  int s0, d0;
  logic [9:0] model_mem [DEPTH];
  logic [9:0] exp_q [$];
  logic [9:0] mon_e;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: each start pops one expected entry; done must follow the last busy fall.
  always @(negedge clk) begin
    if (sd_start) begin
      start_cnt++;
      if (exp_q.size() == 0) begin
        check_val("unexp_start", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        $display("play entry oct=%0d note=%0d len=%0d", octave_out, note_out, length_out);
        check_val("entry", int'({octave_out, note_out, length_out}), int'(mon_e));
      end
    end
    if (done) begin
      done_cnt++;
      check_val("done_lat", cyc, last_fall_cyc + 1);
      check_val("done_busy", int'(busy), 0);
    end
  end

  // Sound-generator model: busy for 5 cycles after each start, unless stalled.
  initial forever begin
    @(negedge clk);
    if (sd_start && rst_n) begin
      if (resp_idx - resp_base != stall_at) begin
        @(posedge clk); #1 sd_busy = 1'b1;
        repeat (5) @(posedge clk);
        #1 sd_busy = 1'b0;
        last_fall_cyc = cyc;
      end
      resp_idx++;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_hit(input logic [2:0] o, input logic [3:0] n, input logic [2:0] l);
    octave_in = o; note_in = n; length_in = l; hit = 1'b1;
    step();
    hit = 1'b0;
    if (model_count < DEPTH) begin
      model_mem[model_count] = {o, n, l};
      model_count++;
    end
    $display("hit oct=%0d note=%0d len=%0d count=%0d", o, n, l, count);
  endtask

  task automatic do_rec();
    rec = 1'b1; step(); rec = 1'b0;
    model_count = 0;
  endtask

  task automatic do_stop();
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic start_play();
    for (int i = 0; i < model_count; i++) exp_q.push_back(model_mem[i]);
    resp_base = resp_idx;
    play = 1'b1; step(); play = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc && busy; i++) @(negedge clk);
    check_val("idle_timeout", int'(busy), 0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_start", int'(sd_start), 0);
    check_val("rst_count", int'(count), 0);
    check_val("rst_full", int'(full), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_done", int'(done), 0);
    check_val("rst_outs", int'({octave_out, note_out, length_out}), 0);
    rst_n = 1'b1; en = 1'b1;
    step();

    // play with nothing recorded
    start_play();
    repeat (3) begin
      check_val("empty_busy", int'(busy), 0);
      step();
    end
    check_val("empty_starts", start_cnt, 0);
    check_val("empty_done", done_cnt, 0);

    // three-note record and playback
    do_rec();
    check_val("rec_busy", int'(busy), 1);
    check_val("rec_count0", int'(count), 0);
    do_hit(3'd4, 4'd1, 3'd2);
    check_val("hit_count1", int'(count), 1);
    do_hit(3'd5, 4'd3, 3'd1);
    do_hit(3'd3, 4'd0, 3'd4);
    do_stop();
    check_val("rec3_count", int'(count), 3);
    check_val("rec3_busy", int'(busy), 0);
    s0 = start_cnt; d0 = done_cnt;
    start_play();
    check_val("play_lat", int'(sd_start), 1);
    wait_idle(200);
    check_val("p3_starts", start_cnt - s0, 3);
    check_val("p3_done", done_cnt - d0, 1);
    check_val("p3_drained", exp_q.size(), 0);

    // saturation at DEPTH
    do_rec();
    for (int i = 0; i < DEPTH + 1; i++) begin
      do_hit(3'($urandom_range(7)), 4'($urandom_range(15)), 3'($urandom_range(7)));
      if (i == DEPTH - 2) check_val("full_early", int'(full), 0);
      if (i == DEPTH - 1) begin
        check_val("full_at32", int'(full), 1);
        check_val("count_at32", int'(count), DEPTH);
      end
    end
    check_val("count_sat", int'(count), DEPTH);
    check_val("full_sat", int'(full), 1);
    do_stop();
    s0 = start_cnt; d0 = done_cnt;
    start_play();
    wait_idle(1000);
    check_val("p32_starts", start_cnt - s0, DEPTH);
    check_val("p32_done", done_cnt - d0, 1);

    // stop while waiting for busy on entry 2
    stall_at = 2;
    s0 = start_cnt; d0 = done_cnt;
    start_play();
    for (int i = 0; i < 200 && start_cnt < s0 + 3; i++) @(negedge clk);
    check_val("stall_reach", start_cnt - s0, 3);
    step();
    do_stop();
    exp_q.delete();
    stall_at = -1;
    check_val("abort_busy", int'(busy), 0);
    check_val("abort_count", int'(count), DEPTH);
    repeat (3) step();
    check_val("abort_nodone", done_cnt - d0, 0);
    s0 = start_cnt;
    start_play();
    wait_idle(1000);
    check_val("replay_starts", start_cnt - s0, DEPTH);

    // rec+play together, then hit+stop together
    rec = 1'b1; play = 1'b1; step(); rec = 1'b0; play = 1'b0;
    model_count = 0;
    check_val("recplay_busy", int'(busy), 1);
    check_val("recplay_count", int'(count), 0);
    do_hit(3'd1, 4'd2, 3'd3);
    check_val("pre_drop_count", int'(count), 1);
    hit = 1'b1; stop = 1'b1; step(); hit = 1'b0; stop = 1'b0;
    check_val("drop_count", int'(count), 1);
    check_val("drop_busy", int'(busy), 0);

    // asynchronous reset while in WAIT
    do_rec();
    do_hit(3'd7, 4'd9, 3'd5);
    do_hit(3'd6, 4'd8, 3'd7);
    do_stop();
    start_play();
    for (int i = 0; i < 50 && !sd_busy; i++) @(negedge clk);
    check_val("wait_reach", int'(sd_busy), 1);
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check_val("arst_start", int'(sd_start), 0);
    check_val("arst_outs", int'({octave_out, note_out, length_out}), 0);
    check_val("arst_count", int'(count), 0);
    check_val("arst_busy", int'(busy), 0);
    check_val("arst_full", int'(full), 0);
    check_val("arst_done", int'(done), 0);
    s0 = start_cnt; d0 = done_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) step();
    check_val("post_rst_starts", start_cnt - s0, 0);
    check_val("post_rst_done", done_cnt - d0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
